// File: rtl/seven_seg_scan_decoder.sv
`timescale 1ns/1ps
// Purpose : recovers BCD digits from a multiplexed, active-low 7-segment display bus.
// Latency : sample STABLE_CYCLES synchronized cycles after a strobe settles (+2 for sync); frame_valid one cycle after the completing sample.
// Backpressure: none; frame_valid/pattern_err/strobe_err are single-cycle pulses with no ready handshake.
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   seg_n[6:0]   : segment lines a..g (bit6 = a), active-low, asynchronous to clk
//   an_n[N-1:0]  : digit strobes, active-low, asynchronous to clk
//   bcd_out      : last complete frame, digit k at [4k+3:4k]
//   frame_valid  : pulses for the one cycle in which bcd_out takes a new frame
//   pattern_err  : pulses when a sampled segment pattern is not a decimal glyph
//   strobe_err   : pulses on the first cycle of each multi-hot strobe episode
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic                    strobe_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_DONE  = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Returns {legal, digit}; anything outside the ten decimal glyphs is illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'b0000001: decode_glyph = {1'b1, 4'd0};
      7'b1001111: decode_glyph = {1'b1, 4'd1};
      7'b0010010: decode_glyph = {1'b1, 4'd2};
      7'b0000110: decode_glyph = {1'b1, 4'd3};
      7'b1001100: decode_glyph = {1'b1, 4'd4};
      7'b0100100: decode_glyph = {1'b1, 4'd5};
      7'b0100000: decode_glyph = {1'b1, 4'd6};
      7'b0001111: decode_glyph = {1'b1, 4'd7};
      7'b0000000: decode_glyph = {1'b1, 4'd8};
      7'b0001100: decode_glyph = {1'b1, 4'd9};
      default:    decode_glyph = 5'b0;
    endcase
  endfunction

  // Number of strobes driven low (at most 8 digits, so 4 bits suffice).
  function automatic logic [3:0] count_low(input logic [NUM_DIGITS-1:0] a);
    count_low = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      count_low = count_low + {3'b000, ~a[i]};
    end
  endfunction

  // Two-flop synchronizers; they idle at all ones (nothing lit, no strobe).
  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] an_s1, an_s2;

  // Previous synchronized pair, used for stability detection.
  logic [6:0]            seg_p;
  logic [NUM_DIGITS-1:0] an_p;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0] mask;
  logic                  frame_pend;

  logic [3:0]            lows;
  logic                  strobe_one;
  logic                  strobe_multi;
  logic                  prev_multi;
  logic                  pair_same;
  logic                  take_sample;
  logic [4:0]            glyph;
  logic                  glyph_legal;
  logic [3:0]            glyph_val;
  logic [NUM_DIGITS-1:0] mask_set;
  logic                  frame_done;

  assign lows         = count_low(an_s2);
  assign strobe_one   = (lows == 4'd1);
  assign strobe_multi = (lows > 4'd1);
  assign prev_multi   = (count_low(an_p) > 4'd1);
  assign pair_same    = (an_s2 == an_p) && (seg_s2 == seg_p);

  assign glyph        = decode_glyph(seg_s2);
  assign glyph_legal  = glyph[4];
  assign glyph_val    = glyph[3:0];

  // While sampling the strobe is one-hot, so ~an_s2 is exactly the digit bit.
  assign mask_set     = mask | ~an_s2;
  assign frame_done   = take_sample && glyph_legal && (mask_set == MASK_FULL);

  // Next-state and stability counter. The cycle that first shows a new
  // one-hot pair counts as 1; the sample fires when the count reaches
  // STABLE_CYCLES, which may be that very first cycle when STABLE_CYCLES=1.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    take_sample = 1'b0;
    if (strobe_multi) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_one) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end
        end
        SETTLE: begin
          if (pair_same) begin
            cnt_d = cnt + CW'(1);
          end else if (strobe_one) begin
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (!pair_same) begin
            if (strobe_one) begin
              state_d = SETTLE;
              cnt_d   = CW'(1);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (state_d == SETTLE && cnt_d == CNT_DONE) begin
        take_sample = 1'b1;
        state_d     = HELD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1      <= '1;
      seg_s2      <= '1;
      an_s1       <= '1;
      an_s2       <= '1;
      seg_p       <= '1;
      an_p        <= '1;
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      mask        <= '0;
      frame_pend  <= 1'b0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      strobe_err  <= 1'b0;
    end else begin
      seg_s1      <= seg_n;
      seg_s2      <= seg_s1;
      an_s1       <= an_n;
      an_s2       <= an_s1;
      seg_p       <= seg_s2;
      an_p        <= an_s2;

      state       <= state_d;
      cnt         <= cnt_d;

      // Only the leading edge of a multi-hot episode is reported.
      strobe_err  <= strobe_multi && !prev_multi;
      pattern_err <= take_sample && !glyph_legal;

      // The frame is published one clock after its last digit lands in the
      // shadow; reading shadow here picks up that digit even if another
      // sample updates shadow on this same edge.
      frame_pend  <= frame_done;
      frame_valid <= frame_pend;
      if (frame_pend) begin
        bcd_out <= shadow;
      end

      if (take_sample) begin
        if (glyph_legal) begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an_s2[k]) begin
              shadow[4*k +: 4] <= glyph_val;
            end
          end
          // Clearing on the completing sample lets the very next sample
          // start collecting the following frame.
          mask <= frame_done ? '0 : mask_set;
        end else begin
          mask <= mask & an_s2;
        end
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of scanned digit positions (1..8).
REQ-002 Parameter: STABLE_CYCLES, default 4, consecutive identical synchronized cycles required before a digit is sampled (>=1).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: seg_n  input  7  segment lines, active-low (0 = lit), bit6 = a through bit0 = g; asynchronous to clk.
REQ-006 Port: an_n  input  NUM_DIGITS  digit strobes, active-low, bit k = digit k; asynchronous to clk.
REQ-007 Port: bcd_out  output  4*NUM_DIGITS  last complete frame, digit k at bits [4k+3:4k].
REQ-008 Port: frame_valid  output  1  one-cycle pulse when bcd_out updates.
REQ-009 Port: pattern_err  output  1  one-cycle pulse when a sampled pattern is not a legal decimal glyph.
REQ-010 Port: strobe_err  output  1  one-cycle pulse when more than one an_n bit is low.

Function
REQ-011 seg_n and an_n SHALL each pass through a 2-flop synchronizer; all further logic uses synchronized values only.
REQ-012 Legal glyph table (seg_n -> digit): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9; every other pattern is illegal.
REQ-013 State machine states: IDLE (no strobe low), SETTLE (one strobe low, counting), HELD (sample taken, waiting for change).
REQ-014 IDLE -> SETTLE when exactly one synchronized strobe is low; stability counter loads 1.
REQ-015 SETTLE: counter increments each cycle the synchronized {an, seg} pair equals the previous cycle's; any change restarts the count at 1 (stays SETTLE if still one-hot, else IDLE).
REQ-016 SETTLE -> HELD on the cycle the counter reaches STABLE_CYCLES; exactly one sample is taken on that cycle.
REQ-017 HELD: no further samples; any change of the pair -> SETTLE (count 1) if one-hot, IDLE if no strobe low.
REQ-018 Multi-hot strobe in any state: strobe_err pulses on the first such cycle of each multi-hot episode, counter clears, state -> IDLE, no sample taken.
REQ-019 Sample of legal glyph on digit k: shadow nibble k <= decoded value, captured-mask bit k <= 1; re-sampling an already captured digit overwrites it.
REQ-020 Sample of illegal glyph on digit k: pattern_err pulses on the sample cycle, captured-mask bit k <= 0, shadow nibble k unchanged.
REQ-021 When a sample sets the last missing mask bit, on the next clock bcd_out <= shadow (including that sample), frame_valid high for exactly that one cycle, captured mask cleared to 0.
REQ-022 Latency: input change at cycle 0 -> sample at cycle 2+STABLE_CYCLES-1 after synchronizer output changes (sync adds 2) -> frame_valid one cycle after completing sample.
REQ-023 bcd_out SHALL hold its value between frame_valid pulses; it never changes without frame_valid.
REQ-024 pattern_err and strobe_err may assert in the same cycle as frame_valid only if caused by independent events; an illegal sample never completes a frame.

Reset
REQ-025 rst_n low SHALL asynchronously force: synchronizer flops all ones, state IDLE, counter 0, shadow 0, captured mask 0, bcd_out 0, frame_valid 0, pattern_err 0, strobe_err 0.
REQ-026 Reset mid-frame SHALL discard partially captured digits; first frame_valid after release requires all NUM_DIGITS digits captured anew.
REQ-027 Outputs SHALL remain at reset values until the first synchronized strobe is observed after rst_n rises.

Verification
REQ-028 Scan digits 0..3 with glyphs for 1,2,3,4, each held 10 cycles -> one frame_valid, bcd_out = 16'h4321.
REQ-029 Digit 2 held only STABLE_CYCLES-1 synchronized cycles then strobes off -> no sample, no frame_valid, bcd_out unchanged.
REQ-030 Digit 1 driven with seg_n = 7'b1111111 for 10 cycles -> single pattern_err pulse, mask bit 1 clear, frame not completed until digit 1 re-scanned legally.
REQ-031 an_n = 4'b0011 for 5 cycles -> single strobe_err pulse, no sample, state IDLE.
REQ-032 Assert rst_n low after digits 0..2 captured, release, scan 9,8,7,6 -> bcd_out = 16'h6789 with exactly one frame_valid, no stale digits.
REQ-033 Continuous rescan of 5,5,5,5 then digit 0 changed to glyph 0 -> successive frame_valid pulses, bcd_out 16'h5555 then 16'h5550.
